inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch_if.sv | 46 ++++
 rtl/inst_fetch.sv | 109 ++++++++++
 tb/tb_inst_fetch.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_if.sv
// Fetch-unit bundle: PC unit, instruction memory and decode/execute sides.
// master is the fetch unit; slave is the environment around it.
interface inst_fetch_if;
  logic [31:0] pc;
  logic        do_update;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] inst;
  logic        inst_valid;
  logic        inst_ready;
  logic        flush;
  logic        fault;
  logic [31:0] fetch_count;

  modport master (
    input  pc,
    input  mem_ack,
    input  mem_rdata,
    input  inst_ready,
    input  flush,
    output do_update,
    output mem_req,
    output mem_addr,
    output inst,
    output inst_valid,
    output fault,
    output fetch_count
  );

  modport slave (
    output pc,
    output mem_ack,
    output mem_rdata,
    output inst_ready,
    output flush,
    input  do_update,
    input  mem_req,
    input  mem_addr,
    input  inst,
    input  inst_valid,
    input  fault,
    input  fetch_count
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: one outstanding word read, hands inst to execute,
// pulses do_update on retire; halts sticky on a misaligned pc.
module inst_fetch (
  input logic         clk,
  input logic         nreset,
  inst_fetch_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    VALID,
    UPDATE,
    HALT
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_inst;
  logic [31:0] w_inst_nxt;
  logic        r_inst_valid;
  logic        w_inst_valid_nxt;
  logic        r_fault;
  logic        w_fault_nxt;
  logic        r_drop;
  logic        w_drop_nxt;
  logic [31:0] r_fetch_count;
  logic [31:0] w_count_nxt;
  logic        w_mem_req;
  logic        w_do_update;
  logic        w_aligned;

  assign w_aligned = (bus.pc[1:0] == 2'b00);

  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_state       <= IDLE;
      r_inst        <= 32'h0;
      r_inst_valid  <= 1'b0;
      r_fault       <= 1'b0;
      r_drop        <= 1'b0;
      r_fetch_count <= 32'h0;
    end else begin
      r_state       <= w_state_nxt;
      r_inst        <= w_inst_nxt;
      r_inst_valid  <= w_inst_valid_nxt;
      r_fault       <= w_fault_nxt;
      r_drop        <= w_drop_nxt;
      r_fetch_count <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_inst_nxt       = r_inst;
    w_inst_valid_nxt = r_inst_valid;
    w_fault_nxt      = r_fault;
    w_drop_nxt       = r_drop;
    w_count_nxt      = r_fetch_count;
    w_mem_req        = 1'b0;
    w_do_update      = 1'b0;
    unique case (r_state)
      IDLE: w_state_nxt = FETCH;
      FETCH: begin
        w_mem_req = w_aligned & nreset;
        if (!w_aligned) begin
          w_fault_nxt = 1'b1;
          w_state_nxt = HALT;
        end else if (bus.mem_ack) begin
          // a flushed request still has to drain its ack
          if (r_drop || bus.flush) begin
            w_drop_nxt = 1'b0;
          end else begin
            w_inst_nxt       = bus.mem_rdata;
            w_inst_valid_nxt = 1'b1;
            w_state_nxt      = VALID;
          end
        end else if (bus.flush) begin
          w_drop_nxt = 1'b1;
        end
      end
      VALID: begin
        if (bus.flush) begin
          w_inst_valid_nxt = 1'b0;
          w_state_nxt      = FETCH;
        end else if (bus.inst_ready) begin
          w_inst_valid_nxt = 1'b0;
          w_state_nxt      = UPDATE;
        end
      end
      UPDATE: begin
        w_do_update = 1'b1;
        w_count_nxt = r_fetch_count + 32'd1;
        w_state_nxt = FETCH;
      end
      HALT: w_state_nxt = HALT;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.mem_req     = w_mem_req;
  assign bus.mem_addr    = {bus.pc[31:2], 2'b00};
  assign bus.do_update   = w_do_update;
  assign bus.inst        = r_inst;
  assign bus.inst_valid  = r_inst_valid;
  assign bus.fault       = r_fault;
  assign bus.fetch_count = r_fetch_count;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: vector table, directed corner cases and a
// randomized run against a transaction-level fetch model.
module tb_inst_fetch;

  logic clk = 1'b0;
  logic nreset;
  int   n_chk = 0;
  int   n_err = 0;

  inst_fetch_if bus ();

  inst_fetch dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        ack;
    logic [31:0] rd;
    logic        rdy;
    logic        fl;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic        upd;
    logic [31:0] inst;
    logic [31:0] cnt;
  } vec_t;

  vec_t vec[$];

  function automatic vec_t mk(
    logic [31:0] pc, logic ack, logic [31:0] rd, logic rdy, logic fl,
    logic req, logic [31:0] addr, logic vld, logic upd,
    logic [31:0] inst, logic [31:0] cnt);
    vec_t v;
    v.pc = pc; v.ack = ack; v.rd = rd; v.rdy = rdy; v.fl = fl;
    v.req = req; v.addr = addr; v.vld = vld; v.upd = upd;
    v.inst = inst; v.cnt = cnt;
    return v;
  endfunction

  function automatic logic [31:0] memw(logic [31:0] a);
    return (a * 32'h9E3779B1) + 32'h01234567;
  endfunction

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(logic [31:0] pc, logic ack, logic [31:0] rd,
                       logic rdy, logic fl);
    bus.pc = pc; bus.mem_ack = ack; bus.mem_rdata = rd;
    bus.inst_ready = rdy; bus.flush = fl;
  endtask

  task automatic do_reset();
    nreset = 1'b0;
    drive(32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    nreset = 1'b1;
  endtask

  // model state for the random run
  bit          m_start, m_fetch, m_drop, m_have, m_retire, m_fault;
  logic [31:0] m_inst, m_cnt, m_pc;
  logic        e_req;
  logic [99:0] e_vec, a_vec;

  initial begin
    nreset = 1'b0;
    drive(32'h0, 1'b1, 32'hBAD0BAD0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", bus.mem_req, 0);
    chk("rst_vld", bus.inst_valid, 0);
    chk("rst_upd", bus.do_update, 0);
    chk("rst_fault", bus.fault, 0);
    chk("rst_inst", bus.inst, 0);
    chk("rst_cnt", bus.fetch_count, 0);

    vec.push_back(mk(0, 0, 0,            1, 0, 0, 0, 0, 0, 0, 0));
    vec.push_back(mk(0, 1, 32'hE3A01005, 1, 0, 1, 0, 0, 0, 0, 0));
    vec.push_back(mk(0, 0, 0,            1, 0, 0, 0, 1, 0, 32'hE3A01005, 0));
    vec.push_back(mk(0, 0, 0,            0, 0, 0, 0, 0, 1, 32'hE3A01005, 0));
    vec.push_back(mk(4, 1, 32'h11111111, 0, 0, 1, 4, 0, 0, 32'hE3A01005, 1));
    vec.push_back(mk(4, 1, 32'h99999999, 1, 1, 0, 4, 1, 0, 32'h11111111, 1));
    vec.push_back(mk(4, 0, 0,            0, 0, 1, 4, 0, 0, 32'h11111111, 1));
    vec.push_back(mk(4, 1, 32'h22222222, 0, 1, 1, 4, 0, 0, 32'h11111111, 1));
    vec.push_back(mk(4, 1, 32'h33333333, 0, 0, 1, 4, 0, 0, 32'h11111111, 1));
    vec.push_back(mk(4, 1, 32'h55555555, 0, 0, 0, 4, 1, 0, 32'h33333333, 1));
    vec.push_back(mk(4, 0, 0,            1, 0, 0, 4, 1, 0, 32'h33333333, 1));
    vec.push_back(mk(4, 0, 0,            0, 1, 0, 4, 0, 1, 32'h33333333, 1));
    vec.push_back(mk(8, 0, 0,            0, 0, 1, 8, 0, 0, 32'h33333333, 2));

    @(negedge clk);
    nreset = 1'b1;
    for (int i = 0; i < vec.size(); i++) begin
      drive(vec[i].pc, vec[i].ack, vec[i].rd, vec[i].rdy, vec[i].fl);
      #1;
      chk($sformatf("vec%0d_req", i), bus.mem_req, vec[i].req);
      if (vec[i].req)
        chk($sformatf("vec%0d_addr", i), bus.mem_addr, vec[i].addr);
      chk($sformatf("vec%0d_vld", i), bus.inst_valid, vec[i].vld);
      chk($sformatf("vec%0d_upd", i), bus.do_update, vec[i].upd);
      chk($sformatf("vec%0d_inst", i), bus.inst, vec[i].inst);
      chk($sformatf("vec%0d_cnt", i), bus.fetch_count, vec[i].cnt);
      chk($sformatf("vec%0d_fault", i), bus.fault, 0);
      @(negedge clk);
    end

    // wait states then backpressure
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      drive(32'h40, (i == 3), (i == 3) ? 32'hCAFEF00D : 32'h11110000 + i,
            1'b0, 1'b0);
      #1;
      chk($sformatf("ws%0d_req", i), bus.mem_req, 1);
      chk($sformatf("ws%0d_addr", i), bus.mem_addr, 32'h40);
      chk($sformatf("ws%0d_vld", i), bus.inst_valid, 0);
      @(negedge clk);
    end
    for (int i = 0; i < 5; i++) begin
      drive(32'h40, 1'b1, 32'h0BADBAD0 + i, 1'b0, 1'b0);
      #1;
      chk($sformatf("bp%0d_inst", i), {bus.inst_valid, bus.inst},
          {1'b1, 32'hCAFEF00D});
      chk($sformatf("bp%0d_upd", i), bus.do_update, 0);
      @(negedge clk);
    end
    drive(32'h40, 1'b0, 32'h0, 1'b1, 1'b0);
    #1 chk("bp_last_vld", bus.inst_valid, 1);
    @(negedge clk);
    bus.inst_ready = 1'b0;
    #1 chk("bp_upd", {bus.do_update, bus.fetch_count}, {1'b1, 32'd0});
    @(negedge clk);
    bus.pc = 32'h44;
    #1 chk("bp_next", {bus.do_update, bus.fetch_count, bus.mem_req, bus.mem_addr},
           {1'b0, 32'd1, 1'b1, 32'h44});

    // flush during an outstanding request, ack two cycles later
    do_reset();
    @(negedge clk);
    drive(32'h80, 1'b0, 32'h0, 1'b1, 1'b1);
    #1 chk("fl_req0", bus.mem_req, 1);
    @(negedge clk);
    drive(32'h80, 1'b0, 32'h0, 1'b1, 1'b0);
    #1 chk("fl_req1", {bus.mem_req, bus.mem_addr}, {1'b1, 32'h80});
    @(negedge clk);
    drive(32'h80, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
    #1 chk("fl_req2", bus.mem_req, 1);
    @(negedge clk);
    drive(32'h80, 1'b1, 32'h600DF00D, 1'b1, 1'b1);
    bus.flush = 1'b0;
    #1 chk("fl_drop", {bus.mem_req, bus.inst_valid, bus.inst},
           {1'b1, 1'b0, 32'h0});
    @(negedge clk);
    drive(32'h80, 1'b0, 32'h0, 1'b1, 1'b1);
    #1 chk("fl_cap", {bus.inst_valid, bus.inst}, {1'b1, 32'h600DF00D});
    @(negedge clk);
    bus.flush = 1'b0;
    bus.inst_ready = 1'b0;
    #1 chk("fl_valid", {bus.inst_valid, bus.do_update, bus.mem_req},
           {1'b0, 1'b0, 1'b1});
    @(negedge clk);
    #1 chk("fl_cnt", {bus.do_update, bus.fetch_count}, {1'b0, 32'd0});

    // misaligned pc halts until reset
    do_reset();
    @(negedge clk);
    drive(32'h102, 1'b1, 32'h12345678, 1'b1, 1'b0);
    #1 chk("flt_req", {bus.mem_req, bus.fault}, {1'b0, 1'b0});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive((i == 2) ? 32'h0 : 32'h102, 1'b1, 32'h12345678, 1'b1, i[0]);
      #1 chk($sformatf("halt%0d", i),
             {bus.mem_req, bus.inst_valid, bus.do_update, bus.fault},
             {1'b0, 1'b0, 1'b0, 1'b1});
    end
    nreset = 1'b0;
    @(negedge clk);
    #1 chk("flt_clr", bus.fault, 0);

    // reset mid-fetch drops the request and any ack
    do_reset();
    @(negedge clk);
    drive(32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    #1 chk("rf_req", bus.mem_req, 1);
    nreset = 1'b0;
    drive(32'h0, 1'b1, 32'h77777777, 1'b1, 1'b0);
    #1 chk("rf_req_rst", bus.mem_req, 0);
    @(negedge clk);
    #1 chk("rf_state", {bus.inst_valid, bus.inst}, {1'b0, 32'h0});

    // counter wrap
    do_reset();
    @(negedge clk);
    drive(32'h0, 1'b1, 32'h00000001, 1'b0, 1'b0);
    @(negedge clk);
    bus.mem_ack = 1'b0;
    force dut.r_fetch_count = 32'hFFFFFFFF;
    #1 release dut.r_fetch_count;
    bus.inst_ready = 1'b1;
    @(negedge clk);
    bus.inst_ready = 1'b0;
    #1 chk("wrap_upd", bus.do_update, 1);
    @(negedge clk);
    #1 chk("wrap_cnt", bus.fetch_count, 32'h0);

    // randomized run against the fetch model
    do_reset();
    m_start = 1; m_fetch = 0; m_drop = 0; m_have = 0;
    m_retire = 0; m_fault = 0;
    m_inst = 0; m_cnt = 0; m_pc = 32'h100;
    for (int c = 0; c < 600; c++) begin
      bus.pc = m_pc;
      bus.flush = ($urandom_range(0, 7) == 0);
      bus.mem_ack = 1'($urandom_range(0, 1));
      bus.inst_ready = 1'($urandom_range(0, 1));
      bus.mem_rdata = bus.mem_ack ? memw(m_pc) : $urandom;
      #1;
      e_req = m_fetch && (m_pc[1:0] == 2'b00);
      e_vec = {e_req, e_req ? {m_pc[31:2], 2'b00} : 32'h0, m_have,
               m_retire, m_fault, m_inst, m_cnt};
      a_vec = {bus.mem_req, bus.mem_req ? bus.mem_addr : 32'h0,
               bus.inst_valid, bus.do_update, bus.fault, bus.inst,
               bus.fetch_count};
      chk($sformatf("rnd%0d", c), a_vec, e_vec);
      if (m_start) begin
        m_start = 0; m_fetch = 1;
      end else if (m_fetch) begin
        if (bus.mem_ack) begin
          if (m_drop || bus.flush) m_drop = 0;
          else begin
            m_inst = memw(m_pc); m_have = 1; m_fetch = 0;
          end
        end else if (bus.flush) m_drop = 1;
      end else if (m_have) begin
        if (bus.flush) begin
          m_have = 0; m_fetch = 1;
        end else if (bus.inst_ready) begin
          m_have = 0; m_retire = 1;
        end
      end else if (m_retire) begin
        m_retire = 0; m_fetch = 1;
        m_cnt = m_cnt + 1;
        m_pc = m_pc + 4;
      end
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
